// File: rtl/count_chk_pkg.sv
// ---------------------------------------------------------------------------
// count_chk_pkg
// Shared definitions for the mod-12 counter checker and its reference model:
// the modulus of the observed counter (12), the highest legal count value
// (11), the 4-bit count type and the checker FSM states (UNSYNC, TRACK).
// ---------------------------------------------------------------------------
package count_chk_pkg;

  localparam int MOD     = 12;
  localparam int MAX_CNT = MOD - 1;

  typedef logic [3:0] count_t;

  typedef enum logic {
    UNSYNC = 1'b0,
    TRACK  = 1'b1
  } chk_state_e;

endpackage

// File: rtl/mod12_model.sv
// ---------------------------------------------------------------------------
// mod12_model
// Purely combinational next-count function of the mod-12 loadable up/down
// counter.
// Ports:
//   prev    in  WIDTH  current count
//   resetn  in  1      synchronous active-low counter reset (highest priority)
//   load    in  1      load din
//   up_down in  1      direction, 1 = up
//   din     in  WIDTH  load data
//   next    out WIDTH  count after the next rising edge
// ---------------------------------------------------------------------------
module mod12_model
  import count_chk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic             resetn,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_CNT);

  // Priority: counter reset, then load, then count.  Counting up from any
  // value at or above 11 (including an illegally loaded 12..15) wraps to 0,
  // so an out-of-range load recovers on the next up step.
  always_comb begin
    next = prev;
    if (!resetn) begin
      next = '0;
    end else if (load) begin
      next = din;
    end else if (up_down) begin
      next = (prev >= MAX_V) ? '0 : prev + 1'b1;
    end else begin
      next = (prev == '0) ? MAX_V : prev - 1'b1;
    end
  end

endmodule

// File: rtl/mod12_count_checker.sv
// ---------------------------------------------------------------------------
// mod12_count_checker
// Run-time checker for the mod-12 loadable up/down counter.  Samples the
// counter's stimulus, predicts its output with mod12_model, compares the
// observed count one cycle later and keeps flags, statistics and the first
// failing pair.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   check_en       compare enable (model keeps tracking when low)
//   resetn, load, up_down, din   observed counter stimulus
//   count          observed counter output
//   synced         model holds a valid prediction
//   mismatch       one-cycle pulse on a failed compare
//   error_seen     sticky: any mismatch since reset
//   illegal_load   sticky: load with din > 11 seen
//   cmp_count      saturating number of compares performed
//   err_count      saturating number of mismatches
//   first_exp/got  expected / observed value at the first mismatch
// ---------------------------------------------------------------------------
module mod12_count_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              check_en,
  input  logic              resetn,
  input  logic              load,
  input  logic              up_down,
  input  logic [WIDTH-1:0]  din,
  input  logic [WIDTH-1:0]  count,
  output logic              synced,
  output logic              mismatch,
  output logic              error_seen,
  output logic              illegal_load,
  output logic [STAT_W-1:0] cmp_count,
  output logic [STAT_W-1:0] err_count,
  output logic [WIDTH-1:0]  first_exp,
  output logic [WIDTH-1:0]  first_got
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_CNT);

  chk_state_e        state_q;
  chk_state_e        state_d;
  logic [WIDTH-1:0]  exp_q;
  logic [WIDTH-1:0]  exp_next;
  logic              exp_update;
  logic              do_cmp;
  logic              cmp_fail;
  logic              mismatch_q;
  logic              error_seen_q;
  logic              illegal_q;
  logic [STAT_W-1:0] cmp_count_q;
  logic [STAT_W-1:0] err_count_q;
  logic [WIDTH-1:0]  first_exp_q;
  logic [WIDTH-1:0]  first_got_q;

  mod12_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .prev   (exp_q),
    .resetn (resetn),
    .load   (load),
    .up_down(up_down),
    .din    (din),
    .next   (exp_next)
  );

  // Next-state logic.  Until a counter reset or load is seen the counter's
  // value is unknown, so the model only starts predicting from such an edge;
  // once tracking, the prediction is refreshed on every edge regardless of
  // check_en so disabling compares never loses sync.
  always_comb begin
    state_d    = state_q;
    exp_update = 1'b0;
    unique case (state_q)
      UNSYNC: begin
        if (!resetn || load) begin
          state_d    = TRACK;
          exp_update = 1'b1;
        end
      end
      TRACK: begin
        exp_update = 1'b1;
      end
      default: begin
        state_d = UNSYNC;
      end
    endcase
  end

  // The prediction in exp_q describes the counter output after the previous
  // edge, which is what count shows now.  The case-inequality makes an X/Z
  // count fail in simulation; hardware sees it as an ordinary inequality.
  always_comb begin
    do_cmp   = (state_q == TRACK) && check_en;
    cmp_fail = do_cmp && (count !== exp_q);
  end

  // FSM state and prediction register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= UNSYNC;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (exp_update) begin
        exp_q <= exp_next;
      end
    end
  end

  // Result flags, saturating statistics and first-failure capture.  The
  // capture registers load only while error_seen is still clear, so the
  // first failing pair survives until the next checker reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mismatch_q   <= 1'b0;
      error_seen_q <= 1'b0;
      illegal_q    <= 1'b0;
      cmp_count_q  <= '0;
      err_count_q  <= '0;
      first_exp_q  <= '0;
      first_got_q  <= '0;
    end else begin
      mismatch_q <= cmp_fail;
      if (do_cmp && (cmp_count_q != '1)) begin
        cmp_count_q <= cmp_count_q + 1'b1;
      end
      if (cmp_fail) begin
        error_seen_q <= 1'b1;
        if (err_count_q != '1) begin
          err_count_q <= err_count_q + 1'b1;
        end
        if (!error_seen_q) begin
          first_exp_q <= exp_q;
          first_got_q <= count;
        end
      end
      if (load && resetn && (din > MAX_V)) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign synced       = (state_q == TRACK);
  assign mismatch     = mismatch_q;
  assign error_seen   = error_seen_q;
  assign illegal_load = illegal_q;
  assign cmp_count    = cmp_count_q;
  assign err_count    = err_count_q;
  assign first_exp    = first_exp_q;
  assign first_got    = first_got_q;

endmodule

// File: doc/mod12_count_checker.md
# mod12_count_checker

Synthesizable run-time checker sitting on the far side of the mod-12 loadable up/down counter. It samples the same stimulus the counter consumes (din, load, up_down, resetn), runs an internal reference model in lock-step, compares every observed count against the prediction, and reports pulses, sticky flags, saturating statistics and first-failure capture. It can be instantiated next to the counter in silicon/FPGA or bound into the bench in place of a software scoreboard.

## Interface
- WIDTH, 4: counter data width.
- STAT_W, 16: width of statistics counters.
- clock  in  1  sole clock; all sampling on rising edge.
- reset  in  1  asynchronous, active-high checker reset.
- check_en  in  1  compare enable; model keeps tracking when low.
- resetn  in  1  observed counter synchronous active-low reset.
- load  in  1  observed counter load.
- up_down  in  1  observed direction (1 = up).
- din  in  WIDTH  observed load data.
- count  in  WIDTH  observed counter output.
- synced  out  1  model holds a valid prediction.
- mismatch  out  1  one-cycle pulse on failed compare.
- error_seen  out  1  sticky: any mismatch since reset.
- illegal_load  out  1  sticky: load seen with din > 11.
- cmp_count  out  STAT_W  compares performed, saturating.
- err_count  out  STAT_W  mismatches, saturating.
- first_exp  out  WIDTH  expected value at first mismatch.
- first_got  out  WIDTH  observed value at first mismatch.

## Operation
- Reference model (priority order, evaluated on sampled inputs): resetn=0 → 0; else load=1 → din; else up_down=1 → (prev ≥ 11 ? 0 : prev+1); else → (prev = 0 ? 11 : prev−1). All arithmetic in WIDTH bits, no overflow beyond 4'hF.
- FSM states: UNSYNC, TRACK.
  - UNSYNC: no compares; on edge sampling resetn=0 or load=1, model loads 0 / din, go TRACK.
  - TRACK: each edge: if check_en, compare count against exp (prediction made on previous edge), then update exp from current inputs.
  - Any X/Z on count while TRACK and check_en counts as mismatch (simulation only; synthesis treats as value).
- Mismatch: mismatch=1 for one cycle, err_count++ (saturate at all-ones), error_seen set; if first, capture first_exp/first_got (never overwritten until reset).
- cmp_count increments on every performed compare, saturating.
- illegal_load set when load=1, resetn=1, din > 11, any state; model still loads din (and wraps to 0 on next up).
- check_en low: no compare, no pulse, statistics frozen, model still updates.

## Timing
- reset asserted: state UNSYNC, synced=0, mismatch=0, error_seen=0, illegal_load=0, counters 0, first_exp/first_got 0; takes effect immediately (async), released synchronously to clock.
- Compare latency: stimulus sampled at edge N, counter output checked at edge N+1; mismatch visible after edge N+1, cleared after N+2 unless repeated.
- synced rises after the syncing edge; first compare on the following edge.
- Simultaneous resetn=0 and load=1: reset wins, exp = 0.
- Wrap: up from 11 → 0; down from 0 → 11; no compare skipped at wrap.
- reset mid-run: all state discarded, back to UNSYNC; requires new sync event.
- Counter saturation: at all-ones both counters hold; error_seen still updates.

## Structure
- Package count_chk_pkg: MOD=12, MAX_CNT=11, typedef count_t logic[3:0], enum chk_state_e {UNSYNC, TRACK}.
- Sub-module mod12_model: combinational next-count function (prev, resetn, load, up_down, din → next); reusable by the bench transaction model.
- Top holds FSM, exp register, comparator, statistics, capture registers.

## Test plan
- Reset then resetn=0 one cycle, 14 up cycles with correct counter → count 0..11,0,1; synced=1, cmp_count=14, err_count=0.
- load din=5, up_down=0 for 7 cycles → expected 5,4,3,2,1,0,11; no mismatch.
- Force count=7 where exp=6 → mismatch pulse one cycle, err_count=1, first_exp=6, first_got=7; second fault later leaves capture unchanged.
- Stimulus before any resetn/load → synced=0, no compares; then load din=3 → tracking from 3.
- load din=14 → illegal_load=1, next up predicts 0; resetn=0 with load=1 same cycle → exp 0.
- Assert reset mid-TRACK with err_count=3 → all outputs to reset values immediately, synced=0; check_en=0 window → counters frozen.
